bisect_root_driver: RTL and testbench

- Initiator side of the start_func/func_done function-evaluator handshake.
- Drives x values into the evaluator, collects the signed 64-bit results, and runs integer bisection on the 32-bit signed x domain to locate a zero crossing of f(x) between lo_in and hi_in.
- Sits above the evaluator; the host starts it with a level start/done handshake.

---
 rtl/bisect_root_driver.sv | 185 ++++++++++++++++++
 tb/tb_bisect_root_driver.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/bisect_root_driver.sv
// bisect_root_driver: integer bisection root finder that drives a start_func/func_done evaluator.
// Define BISECT_TIMEOUT_EN to add a per-request watchdog and the timeout output.
module bisect_root_driver #(
  parameter int MAX_ITER       = 32,
  parameter int ITER_W         = 6,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic signed [31:0] lo_in,
  input  logic signed [31:0] hi_in,
  output logic               done,
  output logic               busy,
  output logic signed [31:0] root,
  output logic               exact,
  output logic               error,
  output logic               ovf,
  output logic [ITER_W-1:0]  iter_cnt,
  output logic               start_func,
  output logic signed [31:0] x_out,
  input  logic               func_done,
  input  logic signed [63:0] y_in,
  input  logic               overflow_in,
`ifdef BISECT_TIMEOUT_EN
  output logic               timeout,
`endif
  output logic [2:0]         dbg_state
);
  // Handshake: start_func rises only from REQ entry, stays high until func_done=1 is seen,
  // and the next request waits until func_done has been observed low again.
  typedef enum logic [2:0] {S_IDLE = 3'd0, S_REQ, S_REL, S_DECIDE, S_DONE} state_e;
  typedef enum logic [1:0] {P_LO = 2'd0, P_HI, P_MID} phase_e;
  localparam logic [ITER_W-1:0] ITER_LIM = ITER_W'(MAX_ITER);

  if ((1 << ITER_W) <= MAX_ITER || TIMEOUT_CYCLES < 1) begin : g_bad_cfg
    $error("bisect_root_driver: invalid parameter set");
  end

  state_e             state_q, state_d;
  phase_e             phase_q, phase_d;
  logic signed [31:0] lo_q, lo_d, hi_q, hi_d, x_q, x_d, root_q, root_d;
  logic [63:0]        y_q, y_d;
  logic               yov_q, yov_d, flo_q, flo_d;
  logic               exact_q, exact_d, error_q, error_d, ovf_q, ovf_d;
  logic               done_q, done_d, busy_q, busy_d, sf_q, sf_d;
  logic [ITER_W-1:0]  iter_q, iter_d;

`ifdef BISECT_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] tmo_cnt_q;
  logic          tmo_q, tmo_hit, waiting;
  assign waiting = (state_q == S_REQ) || (state_q == S_REL);
  assign tmo_hit = waiting && (tmo_cnt_q == TW'(TIMEOUT_CYCLES - 1));
  always_ff @(posedge clk) begin
    if (rst) begin
      tmo_cnt_q <= '0;
      tmo_q     <= 1'b0;
    end else begin
      if (!waiting)     tmo_cnt_q <= '0;
      else if (!tmo_hit) tmo_cnt_q <= tmo_cnt_q + 1'b1;
      if (state_q == S_IDLE && start)                      tmo_q <= 1'b0;
      else if (tmo_hit && !(state_q == S_REQ && func_done)) tmo_q <= 1'b1;
    end
  end
  assign timeout = tmo_q;
`else
  logic tmo_q, tmo_hit;
  assign tmo_q   = 1'b0;
  assign tmo_hit = 1'b0;
`endif

  // Decision datapath: bracket update for a midpoint result and the next midpoint.
  logic               y_zero, same_sign, converged;
  logic signed [31:0] lo_n, hi_n, mid;
  logic signed [32:0] span, sum;
  logic [ITER_W-1:0]  iter_n;
  always_comb begin
    y_zero    = (y_q == 64'd0);
    same_sign = (y_q[63] == flo_q);
    lo_n      = lo_q;
    hi_n      = hi_q;
    iter_n    = iter_q;
    if (phase_q == P_MID) begin
      iter_n = iter_q + 1'b1;
      if (same_sign) lo_n = x_q;
      else           hi_n = x_q;
    end
    span      = {hi_n[31], hi_n} - {lo_n[31], lo_n};
    sum       = {lo_n[31], lo_n} + {hi_n[31], hi_n};
    mid       = sum[32:1];
    converged = (span <= 33'sd1) || (iter_n == ITER_LIM);
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = (lo_in >= hi_in) ? S_DONE : S_REQ;
      S_REQ:    if (func_done || tmo_hit) state_d = S_REL;
      S_REL:    if (!func_done) state_d = (tmo_q || tmo_hit) ? S_DONE : S_DECIDE;
      S_DECIDE: begin
        if (yov_q)               state_d = S_DONE;
        else if (phase_q == P_LO) state_d = y_zero ? S_DONE : S_REQ;
        else if (y_zero || (phase_q == P_HI && same_sign) || converged) state_d = S_DONE;
        else                     state_d = S_REQ;
      end
      S_DONE:   if (!start) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_comb begin
    phase_d = phase_q;  lo_d = lo_q;  hi_d = hi_q;  x_d = x_q;  root_d = root_q;
    y_d = y_q;  yov_d = yov_q;  flo_d = flo_q;  iter_d = iter_q;
    exact_d = exact_q;  error_d = error_q;  ovf_d = ovf_q;
    sf_d   = (state_d == S_REQ);
    done_d = (state_d == S_DONE);
    busy_d = (state_d == S_REQ) || (state_d == S_REL) || (state_d == S_DECIDE);
    unique case (state_q)
      S_IDLE: if (start) begin
        lo_d = lo_in;  hi_d = hi_in;  x_d = lo_in;  phase_d = P_LO;  root_d = '0;
        iter_d = '0;  exact_d = 1'b0;  ovf_d = 1'b0;  error_d = (lo_in >= hi_in);
      end
      S_REQ: if (func_done) begin
        y_d   = y_in;
        yov_d = overflow_in;
      end
      S_DECIDE: begin
        if (yov_q) ovf_d = 1'b1;
        else if (phase_q == P_LO) begin
          if (y_zero) begin
            root_d = lo_q;  exact_d = 1'b1;
          end else begin
            flo_d = y_q[63];  phase_d = P_HI;  x_d = hi_q;
          end
        end else begin
          if (phase_q == P_MID) iter_d = iter_n;
          if (y_zero) begin
            root_d = (phase_q == P_HI) ? hi_q : x_q;
            exact_d = 1'b1;
          end else if (phase_q == P_HI && same_sign) begin
            error_d = 1'b1;
          end else begin
            lo_d = lo_n;  hi_d = hi_n;
            if (converged) root_d = lo_n;
            else begin
              x_d = mid;  phase_d = P_MID;
            end
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      phase_q <= P_LO;  lo_q <= '0;  hi_q <= '0;  x_q <= '0;  root_q <= '0;
      y_q <= '0;  yov_q <= 1'b0;  flo_q <= 1'b0;  iter_q <= '0;
      exact_q <= 1'b0;  error_q <= 1'b0;  ovf_q <= 1'b0;
      done_q <= 1'b0;  busy_q <= 1'b0;  sf_q <= 1'b0;
    end else begin
      phase_q <= phase_d;  lo_q <= lo_d;  hi_q <= hi_d;  x_q <= x_d;  root_q <= root_d;
      y_q <= y_d;  yov_q <= yov_d;  flo_q <= flo_d;  iter_q <= iter_d;
      exact_q <= exact_d;  error_q <= error_d;  ovf_q <= ovf_d;
      done_q <= done_d;  busy_q <= busy_d;  sf_q <= sf_d;
    end
  end

  assign done       = done_q;
  assign busy       = busy_q;
  assign root       = root_q;
  assign exact      = exact_q;
  assign error      = error_q;
  assign ovf        = ovf_q;
  assign iter_cnt   = iter_q;
  assign start_func = sf_q;
  assign x_out      = x_q;
  assign dbg_state  = state_q;
endmodule

// File: tb/tb_bisect_root_driver.sv
// Directed bench for bisect_root_driver: two instances (MAX_ITER 32 and 4) against an f(x)=x-300 responder.
// With BISECT_TIMEOUT_EN defined the watchdog scenario is also exercised.
module tb_bisect_root_driver;
  logic               clk = 1'b0;
  logic               rst;
  logic               start;
  logic signed [31:0] lo_in, hi_in;

  logic               done_w [2];
  logic               busy_w [2];
  logic [31:0]        root_w [2];
  logic               exact_w [2];
  logic               error_w [2];
  logic               ovf_w [2];
  logic [5:0]         iter_w [2];
  logic               sf_w [2];
  logic [31:0]        x_w [2];
  logic               fd_w [2];
  logic [63:0]        y_w [2];
  logic               ov_w [2];
  logic [2:0]         st_w [2];
`ifdef BISECT_TIMEOUT_EN
  logic               tmo_w [2];
`endif

  int lat = 3, hold = 0, ovf_nth = 0;
  logic silent = 1'b0;
  int viol = 0;
  int n_chk = 0, n_fail = 0;
  logic [31:0] obs0_q[$], obs1_q[$];
  logic [31:0] exp_q[$];

  always #5 clk = ~clk;

  bisect_root_driver u0 (
    .clk(clk), .rst(rst), .start(start), .lo_in(lo_in), .hi_in(hi_in),
    .done(done_w[0]), .busy(busy_w[0]), .root(root_w[0]), .exact(exact_w[0]),
    .error(error_w[0]), .ovf(ovf_w[0]), .iter_cnt(iter_w[0]), .start_func(sf_w[0]),
    .x_out(x_w[0]), .func_done(fd_w[0]), .y_in(y_w[0]), .overflow_in(ov_w[0]),
`ifdef BISECT_TIMEOUT_EN
    .timeout(tmo_w[0]),
`endif
    .dbg_state(st_w[0])
  );

  bisect_root_driver #(.MAX_ITER(4)) u1 (
    .clk(clk), .rst(rst), .start(start), .lo_in(lo_in), .hi_in(hi_in),
    .done(done_w[1]), .busy(busy_w[1]), .root(root_w[1]), .exact(exact_w[1]),
    .error(error_w[1]), .ovf(ovf_w[1]), .iter_cnt(iter_w[1]), .start_func(sf_w[1]),
    .x_out(x_w[1]), .func_done(fd_w[1]), .y_in(y_w[1]), .overflow_in(ov_w[1]),
`ifdef BISECT_TIMEOUT_EN
    .timeout(tmo_w[1]),
`endif
    .dbg_state(st_w[1])
  );

  // Evaluator model f(x) = x - 300 with configurable latency and release hold.
  for (genvar k = 0; k < 2; k++) begin : g_resp
    int   ph, cnt, nreq;
    logic prev_sf;
    always @(posedge clk) begin
      if (rst) begin
        ph <= 0;  cnt <= 0;  nreq <= 0;  fd_w[k] <= 1'b0;  y_w[k] <= '0;  ov_w[k] <= 1'b0;
      end else begin
        if (!start) nreq <= 0;
        case (ph)
          0: if (sf_w[k] && !silent) begin
            cnt <= 1;  ph <= 1;  nreq <= nreq + 1;
          end
          1: if (cnt >= lat) begin
            fd_w[k] <= 1'b1;
            y_w[k]  <= {{32{x_w[k][31]}}, x_w[k]} - 64'd300;
            ov_w[k] <= (nreq == ovf_nth);
            ph <= 2;
          end else cnt <= cnt + 1;
          2: if (!sf_w[k]) begin
            if (hold == 0) begin
              fd_w[k] <= 1'b0;  ph <= 0;
            end else begin
              cnt <= 1;  ph <= 3;
            end
          end
          default: if (cnt >= hold) begin
            fd_w[k] <= 1'b0;  ph <= 0;
          end else cnt <= cnt + 1;
        endcase
      end
    end
    always @(negedge clk) begin
      if (sf_w[k] && !prev_sf) begin
        if (k == 0) obs0_q.push_back(x_w[k]);
        else        obs1_q.push_back(x_w[k]);
        if (fd_w[k]) viol++;
      end
      prev_sf <= sf_w[k];
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_seq(input string tag, input int k);
    int n;
    n = (k == 0) ? obs0_q.size() : obs1_q.size();
    chk({tag, "_nreq"}, n, exp_q.size());
    for (int i = 0; i < exp_q.size() && i < n; i++)
      chk(tag, (k == 0) ? obs0_q[i] : obs1_q[i], exp_q[i]);
  endtask

  task automatic run(input int lo, input int hi, input int budget);
    @(negedge clk);
    lo_in = lo;  hi_in = hi;
    obs0_q.delete();  obs1_q.delete();
    start = 1'b1;
    for (int i = 0; i < budget && !(done_w[0] && done_w[1]); i++) @(negedge clk);
    chk("run_done", done_w[0] && done_w[1], 1'b1);
  endtask

  task automatic release_start();
    start = 1'b0;
    for (int i = 0; i < 10 && (done_w[0] || done_w[1]); i++) @(negedge clk);
    chk("done_clear", done_w[0] || done_w[1], 1'b0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;  start = 1'b0;  lo_in = '0;  hi_in = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_done", done_w[0], 1'b0);
    chk("rst_busy", busy_w[0], 1'b0);
    chk("rst_sf", sf_w[0], 1'b0);
    chk("rst_root", root_w[0], 32'd0);
    chk("rst_iter", iter_w[0], 6'd0);
    rst = 1'b0;
    @(negedge clk);

    // Full bisection to the exact root, plus the MAX_ITER=4 instance stopping early.
    run(0, 1024, 2000);
    exp_q = '{32'd0, 32'd1024, 32'd512, 32'd256, 32'd384, 32'd320, 32'd288, 32'd304, 32'd296, 32'd300};
    check_seq("t1_seq", 0);
    chk("t1_root", root_w[0], 32'd300);
    chk("t1_exact", exact_w[0], 1'b1);
    chk("t1_iter", iter_w[0], 6'd8);
    chk("t1_error", error_w[0], 1'b0);
    chk("t1_busy", busy_w[0], 1'b0);
    exp_q = '{32'd0, 32'd1024, 32'd512, 32'd256, 32'd384, 32'd320};
    check_seq("t2_seq", 1);
    chk("t2_root", root_w[1], 32'd256);
    chk("t2_exact", exact_w[1], 1'b0);
    chk("t2_iter", iter_w[1], 6'd4);
    repeat (3) @(negedge clk);
    chk("t1_done_held", done_w[0], 1'b1);
    release_start();
    chk("t1_root_kept", root_w[0], 32'd300);

    // Slow responder that keeps func_done high after start_func drops.
    lat = 20;  hold = 5;  viol = 0;
    run(0, 1024, 4000);
    exp_q = '{32'd0, 32'd1024, 32'd512, 32'd256, 32'd384, 32'd320, 32'd288, 32'd304, 32'd296, 32'd300};
    check_seq("hs_seq", 0);
    chk("hs_root", root_w[0], 32'd300);
    chk("hs_iter", iter_w[0], 6'd8);
    chk("hs_viol", viol, 0);
    release_start();
    lat = 3;  hold = 0;

    // Bracket checks.
    run(0, 100, 500);
    chk("br_same_nreq", obs0_q.size(), 2);
    chk("br_same_err", error_w[0], 1'b1);
    chk("br_same_root", root_w[0], 32'd0);
    release_start();
    run(100, 100, 500);
    chk("br_eq_nreq", obs0_q.size(), 0);
    chk("br_eq_err", error_w[0], 1'b1);
    release_start();
    run(300, 1000, 500);
    chk("br_lo_nreq", obs0_q.size(), 1);
    chk("br_lo_root", root_w[0], 32'd300);
    chk("br_lo_exact", exact_w[0], 1'b1);
    chk("br_lo_err", error_w[0], 1'b0);
    release_start();

    // Overflow on the third response aborts the run.
    ovf_nth = 3;
    run(0, 1024, 500);
    repeat (20) @(negedge clk);
    chk("ov_flag", ovf_w[0], 1'b1);
    chk("ov_done", done_w[0], 1'b1);
    chk("ov_nreq", obs0_q.size(), 3);
    chk("ov_exact", exact_w[0], 1'b0);
    release_start();
    ovf_nth = 0;

    // Reset while the second request is outstanding.
    @(negedge clk);
    lo_in = 0;  hi_in = 1024;  start = 1'b1;
    for (int i = 0; i < 200 && !(sf_w[0] && x_w[0] == 32'd1024); i++) @(negedge clk);
    chk("mr_reached", sf_w[0] && x_w[0] == 32'd1024, 1'b1);
    rst = 1'b1;
    @(negedge clk);
    chk("mr_sf", sf_w[0], 1'b0);
    chk("mr_busy", busy_w[0], 1'b0);
    chk("mr_done", done_w[0], 1'b0);
    chk("mr_x", x_w[0], 32'd0);
    chk("mr_root", root_w[0], 32'd0);
    start = 1'b0;
    rst = 1'b0;
    repeat (2) @(negedge clk);

`ifdef BISECT_TIMEOUT_EN
    silent = 1'b1;
    run(0, 1024, 300);
    chk("to_flag", tmo_w[0], 1'b1);
    chk("to_ovf", ovf_w[0], 1'b0);
    chk("to_sf", sf_w[0], 1'b0);
    chk("to_nreq", obs0_q.size(), 1);
    release_start();
    silent = 1'b0;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
